// File: rtl/lfsr_burst_arbiter.sv
// Round-robin owner of a shared 8-bit LFSR core: loads the winner's seed/taps, then streams req_len bytes.
// Optional: define LFSR_ABORT_EN to add the abort input and aborted output.
module lfsr_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] req_seed,
  input  logic [NUM_REQ*8-1:0] req_taps,
  input  logic [NUM_REQ*8-1:0] req_len,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_owner,
  output logic                 lfsr_load,
  output logic                 lfsr_enable,
  output logic [7:0]           lfsr_seed,
  output logic [7:0]           lfsr_taps,
  input  logic [7:0]           lfsr_in
`ifdef LFSR_ABORT_EN
  ,
  input  logic                 abort,
  output logic                 aborted
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [7:0]       remaining;
  logic [7:0]       seed_q;
  logic [7:0]       taps_q;

  logic [7:0]       seed_arr [NUM_REQ];
  logic [7:0]       taps_arr [NUM_REQ];
  logic [7:0]       len_arr  [NUM_REQ];

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             hs;
  logic             last_hs;
  logic             abort_run;
  logic [NUM_REQ-1:0] owner_onehot;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      seed_arr[i] = req_seed[i*8 +: 8];
      taps_arr[i] = req_taps[i*8 +: 8];
      len_arr[i]  = req_len[i*8 +: 8];
    end
  end

  // Round-robin scan: first set request at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  assign hs      = out_valid & out_ready;
  assign last_hs = hs && (remaining == 8'd1);

`ifdef LFSR_ABORT_EN
  assign abort_run = (state == RUN) && abort;
`else
  assign abort_run = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pick_found) state_nxt = (len_arr[pick_idx] != 8'd0) ? LOAD : DONE;
      LOAD: state_nxt = RUN;
      RUN:  if (abort_run || last_hs) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      remaining <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (pick_found) begin
          owner     <= pick_idx;
          remaining <= len_arr[pick_idx];
        end
        RUN:  if (hs) remaining <= remaining - 8'd1;
        DONE: rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

  // Seed and taps are pure data: captured at arbitration, gated on the outputs.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_found) begin
      seed_q <= seed_arr[pick_idx];
      taps_q <= taps_arr[pick_idx];
    end
  end

`ifdef LFSR_ABORT_EN
  logic aborted_q;
  // Remembers whether the RUN->DONE transition was an early exit.
  always_ff @(posedge clk) begin
    if (rst) aborted_q <= 1'b0;
    else     aborted_q <= abort_run && !last_hs;
  end
  assign aborted = (state == DONE) && aborted_q;
`endif

  assign owner_onehot = NUM_REQ'(1) << owner;
  assign gnt          = (state == LOAD || state == RUN) ? owner_onehot : '0;
  assign done         = (state == DONE) ? owner_onehot : '0;
  assign out_valid    = (state == RUN);
  assign out_data     = lfsr_in;
  assign out_owner    = owner;
  assign lfsr_load    = (state == LOAD);
  assign lfsr_enable  = hs;
  assign lfsr_seed    = (state == LOAD) ? seed_q : 8'd0;
  assign lfsr_taps    = (state == LOAD || state == RUN) ? taps_q : 8'd0;

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Bench for lfsr_burst_arbiter: directed vector table, hand sequences, and a randomized scoreboard run.
module tb_lfsr_burst_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*8-1:0] seed_bus, taps_bus, len_bus;
  logic [N-1:0]  gnt, done;
  logic [7:0]    out_data;
  logic          out_valid, out_ready;
  logic [1:0]    out_owner;
  logic          lfsr_load, lfsr_enable;
  logic [7:0]    lfsr_seed, lfsr_taps;
  logic [7:0]    core_q = 8'h00;
`ifdef LFSR_ABORT_EN
  logic          abort, aborted;
`endif

  logic [7:0] cfg_seed [N];
  logic [7:0] cfg_taps [N];
  logic [7:0] cfg_len  [N];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      seed_bus[i*8 +: 8] = cfg_seed[i];
      taps_bus[i*8 +: 8] = cfg_taps[i];
      len_bus[i*8 +: 8]  = cfg_len[i];
    end
  end

  lfsr_burst_arbiter #(.NUM_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_seed(seed_bus), .req_taps(taps_bus), .req_len(len_bus),
    .gnt(gnt), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_owner(out_owner),
    .lfsr_load(lfsr_load), .lfsr_enable(lfsr_enable),
    .lfsr_seed(lfsr_seed), .lfsr_taps(lfsr_taps), .lfsr_in(core_q)
`ifdef LFSR_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  // Stand-in core: left shift, feedback parity of stages selected by taps (tap bit k -> stage k-1);
  // the all-zero state recovers to 0x19.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] t);
    if (s == 8'h00) return 8'h19;
    return {s[6:0], ^(s & {1'b0, t[7:1]})};
  endfunction

  always @(posedge clk) begin
    if (lfsr_load)        core_q <= lfsr_seed;
    else if (lfsr_enable) core_q <= lfsr_step(core_q, lfsr_taps);
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  int          cyc = 0;
  int          n_load, n_done, load_cyc, first_valid_cyc, n_aborted;
  logic [7:0]  words[$];
  logic [N-1:0] done_log[$];
  logic [N-1:0] mon_gnt, mon_done;
  logic        mon_valid, mon_load, mon_en;
  logic [7:0]  mon_seed, mon_taps, mon_data;
  logic [1:0]  mon_owner;

  bit          sb_en = 0;
  logic [N-1:0] req_prev = '0;
  bit          m_active;
  int          m_owner, m_left, m_ptr, idle_wait, bursts;
  logic [7:0]  m_word, m_taps;

  task automatic clear_mon();
    n_load = 0; n_done = 0; load_cyc = -1; first_valid_cyc = -1; n_aborted = 0;
    words.delete(); done_log.delete();
  endtask

  always @(negedge clk) begin
    int e;
    cyc++;
    mon_gnt = gnt; mon_done = done; mon_valid = out_valid; mon_load = lfsr_load;
    mon_en = lfsr_enable; mon_seed = lfsr_seed; mon_taps = lfsr_taps;
    mon_data = out_data; mon_owner = out_owner;
    if (lfsr_load) begin n_load++; if (load_cyc < 0) load_cyc = cyc; end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (out_valid && out_ready) words.push_back(out_data);
    if (done != '0) begin n_done++; done_log.push_back(done); end
`ifdef LFSR_ABORT_EN
    if (aborted) n_aborted++;
`endif
    if (sb_en) begin
      if (lfsr_load) begin
        e = rr_pick(m_ptr, req_prev);
        chk("sb_load_idle", m_active, 0);
        chk("sb_load_owner", out_owner, e);
        if (e >= 0) begin
          chk("sb_load_seed", lfsr_seed, cfg_seed[e]);
          m_active = 1; m_owner = e; m_left = cfg_len[e];
          m_word = cfg_seed[e]; m_taps = cfg_taps[e];
        end
      end
      chk("sb_valid_in_burst", out_valid && !m_active, 0);
      if (out_valid && m_active) begin
        chk("sb_data", out_data, m_word);
        chk("sb_gnt", gnt, 1 << m_owner);
        chk("sb_taps", lfsr_taps, m_taps);
        if (out_ready) begin m_left--; m_word = lfsr_step(m_word, m_taps); end
      end
      chk("sb_enable", lfsr_enable, out_valid && out_ready);
      if (done != '0) begin
        if (m_active) begin
          chk("sb_done_owner", done, 1 << m_owner);
          chk("sb_done_count", m_left, 0);
          e = m_owner;
        end else begin
          e = rr_pick(m_ptr, req_prev);
          chk("sb_zero_len_owner", done, (e >= 0) ? (1 << e) : 0);
          if (e >= 0) chk("sb_zero_len", cfg_len[e], 0);
        end
        if (e >= 0) m_ptr = (e + 1) % N;
        m_active = 0; bursts++;
      end
      if (req_prev != '0 && !m_active && !lfsr_load && done == '0) idle_wait++;
      else idle_wait = 0;
      chk("sb_progress", idle_wait > 3, 0);
    end
    req_prev = req;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int k = 0; k < budget && n_done == 0; k++) tick();
    if (n_done == 0) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    int idx; logic [7:0] seed; logic [7:0] taps; logic [7:0] len;
    logic [7:0] w0; logic [7:0] w1; logic [7:0] w2;
  } vec_t;
  vec_t vt[5];

  initial begin
    int req_cyc;
    logic [7:0] w;
    vt[0] = '{0, 8'h19, 8'hB8, 8'd3, 8'h19, 8'h32, 8'h65};
    vt[1] = '{1, 8'h01, 8'hB8, 8'd3, 8'h01, 8'h02, 8'h04};
    vt[2] = '{3, 8'h00, 8'hB8, 8'd2, 8'h00, 8'h19, 8'h00};
    vt[3] = '{2, 8'h80, 8'h03, 8'd2, 8'h80, 8'h00, 8'h00};
    vt[4] = '{1, 8'hC3, 8'h12, 8'd1, 8'hC3, 8'h00, 8'h00};

    req = '0; out_ready = 1'b1; rst = 1'b1;
`ifdef LFSR_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin cfg_seed[i] = 8'h00; cfg_taps[i] = 8'h00; cfg_len[i] = 8'h00; end
    tick(); tick(); tick();
    chk("rst_gnt", mon_gnt, 0);       chk("rst_done", mon_done, 0);
    chk("rst_valid", mon_valid, 0);   chk("rst_load", mon_load, 0);
    chk("rst_enable", mon_en, 0);     chk("rst_seed", mon_seed, 0);
    chk("rst_taps", mon_taps, 0);     chk("rst_owner", mon_owner, 0);
    rst = 1'b0; tick();

    // Directed single bursts
    for (int v = 0; v < 5; v++) begin
      clear_mon();
      cfg_seed[vt[v].idx] = vt[v].seed; cfg_taps[vt[v].idx] = vt[v].taps; cfg_len[vt[v].idx] = vt[v].len;
      req[vt[v].idx] = 1'b1; req_cyc = cyc + 1;
      wait_done("vec", 60);
      req = '0; tick(); tick();
      chk("vec_load_lat", load_cyc - req_cyc, 1);
      chk("vec_valid_lat", first_valid_cyc - req_cyc, 2);
      chk("vec_nwords", words.size(), vt[v].len);
      for (int k = 0; k < words.size() && k < 3; k++) begin
        w = (k == 0) ? vt[v].w0 : (k == 1) ? vt[v].w1 : vt[v].w2;
        chk("vec_word", words[k], w);
      end
      chk("vec_ndone", n_done, 1);
      if (done_log.size() > 0) chk("vec_done_vec", done_log[0], 1 << vt[v].idx);
    end

    // Round-robin from rr_ptr=0 with all four requesting single-byte bursts
    do_reset(); clear_mon();
    for (int i = 0; i < N; i++) begin cfg_seed[i] = 8'h10 + 8'(i); cfg_taps[i] = 8'hB8; cfg_len[i] = 8'd1; end
    req = 4'b1111;
    for (int k = 0; k < 100 && n_done < 5; k++) tick();
    req = '0; tick(); tick();
    chk("rr_ndone", n_done, 5);
    chk("rr_nload", n_load, 5);
    for (int k = 0; k < done_log.size() && k < 5; k++) chk("rr_order", done_log[k], 1 << (k % N));

    // Zero length on requester 2, then rr_ptr must favour 3 over 0 and 1
    clear_mon();
    cfg_len[2] = 8'd0; req[2] = 1'b1;
    wait_done("zl", 30);
    req = '0; tick(); tick();
    chk("zl_nload", n_load, 0);
    chk("zl_nwords", words.size(), 0);
    chk("zl_valid_seen", first_valid_cyc, -1);
    if (done_log.size() > 0) chk("zl_done", done_log[0], 4'b0100);
    clear_mon(); req = 4'b1011;
    wait_done("zl_next", 30);
    req = '0; tick(); tick();
    if (done_log.size() > 0) chk("zl_next_owner", done_log[0], 4'b1000);

    // Backpressure: ready low for the first five valid cycles
    clear_mon();
    cfg_seed[1] = 8'h5A; cfg_taps[1] = 8'hB8; cfg_len[1] = 8'd2;
    out_ready = 1'b0; req[1] = 1'b1;
    for (int k = 0; k < 20 && first_valid_cyc < 0; k++) tick();
    chk("bp_first_valid", first_valid_cyc >= 0, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("bp_valid", mon_valid, 1);
      chk("bp_hold", mon_data, 8'h5A);
      chk("bp_enable", mon_en, 0);
    end
    out_ready = 1'b1;
    wait_done("bp", 20);
    req = '0; tick(); tick();
    chk("bp_nwords", words.size(), 2);
    if (words.size() == 2) begin
      chk("bp_w0", words[0], 8'h5A);
      chk("bp_w1", words[1], lfsr_step(8'h5A, 8'hB8));
    end

    // Reset in the middle of a 4-word burst
    clear_mon();
    cfg_seed[0] = 8'h33; cfg_taps[0] = 8'hB8; cfg_len[0] = 8'd4; req[0] = 1'b1;
    for (int k = 0; k < 20 && words.size() < 1; k++) tick();
    chk("mr_one_word", words.size(), 1);
    rst = 1'b1; tick(); rst = 1'b0; req = '0; tick();
    chk("mr_gnt", mon_gnt, 0);     chk("mr_valid", mon_valid, 0);
    chk("mr_load", mon_load, 0);   chk("mr_enable", mon_en, 0);
    chk("mr_seed", mon_seed, 0);   chk("mr_taps", mon_taps, 0);
    chk("mr_owner", mon_owner, 0); chk("mr_done_now", mon_done, 0);
    tick(); tick(); tick();
    chk("mr_no_done", n_done, 0);

`ifdef LFSR_ABORT_EN
    clear_mon();
    cfg_seed[0] = 8'h19; cfg_taps[0] = 8'hB8; cfg_len[0] = 8'd10; req[0] = 1'b1;
    for (int k = 0; k < 20 && words.size() < 2; k++) tick();
    out_ready = 1'b0; abort = 1'b1; tick(); abort = 1'b0; out_ready = 1'b1;
    wait_done("ab", 10);
    req = '0; tick(); tick();
    chk("ab_nwords", words.size(), 2);
    chk("ab_ndone", n_done, 1);
    chk("ab_aborted", n_aborted, 1);
`endif

    // Randomized traffic against the scoreboard
    do_reset();
    m_active = 0; m_ptr = 0; idle_wait = 0; bursts = 0; sb_en = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (mon_done[i]) req[i] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          cfg_seed[i] = 8'($urandom_range(0, 255));
          cfg_taps[i] = 8'($urandom_range(0, 255));
          cfg_len[i]  = 8'($urandom_range(0, 6));
          req[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 300 && (req != '0 || m_active); k++) begin
      for (int i = 0; i < N; i++) if (req[i] && mon_done[i]) req[i] = 1'b0;
      tick();
    end
    tick(); tick();
    sb_en = 0;
    chk("rand_drained", req, 0);
    chk("rand_bursts_seen", bursts > 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
